// File: rtl/ctrl_decode_pipe.sv
// RV64I+Zba+M control decoder: registers the decoded control word into ID/EX and
// sequences multi-cycle MUL/DIV ops, stalling the front end until the result is ready.
module ctrl_decode_pipe #(
    parameter int XLEN    = 64,
    parameter bit EN_ZBA  = 1'b1,
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        stall_e,
    input  logic        flush_e,
    output logic        regwrite_e,
    output logic        memwrite_e,
    output logic [1:0]  resultsrc_e,
    output logic        alusrc_e,
    output logic        alu_a_pc_e,
    output logic [2:0]  immsrc_e,
    output logic [4:0]  aluctrl_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic        is_jalr_e,
    output logic [3:0]  md_op_e,
    output logic        md_en_e,
    output logic        illegal_e,
    output logic        stall_o,
    output logic        md_done
);
    localparam bit RV64    = (XLEN == 64);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    localparam logic [4:0] A_ADD = 5'b00000, A_SUB = 5'b00001, A_AND = 5'b00010, A_OR = 5'b00011;
    localparam logic [4:0] A_XOR = 5'b00100, A_SLL = 5'b00101, A_SRL = 5'b00110, A_SRA = 5'b00111;
    localparam logic [4:0] A_ADDW = 5'b01000, A_SUBW = 5'b01001, A_SLT = 5'b01010, A_SLTU = 5'b01011;
    localparam logic [4:0] A_SLLW = 5'b01100, A_SRLW = 5'b01101, A_SRAW = 5'b01110;
    localparam logic [4:0] A_SH1 = 5'b10000, A_SH2 = 5'b10001, A_SH3 = 5'b10010;
    localparam logic [4:0] A_ADDUW = 5'b10011, A_SH1UW = 5'b10100, A_SH2UW = 5'b10101, A_SH3UW = 5'b10110;

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic       alusrc;
        logic       alu_a_pc;
        logic [2:0] immsrc;
        logic [4:0] aluctrl;
        logic       branch;
        logic       jump;
        logic       is_jalr;
        logic [3:0] md_op;
        logic       md_en;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    ctrl_t            dec;
    ctrl_t            ctrl_q, ctrl_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             legal;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             unused_fields;

    assign f3 = instr_d[14:12];
    assign f7 = instr_d[31:25];
    assign unused_fields = ^{instr_d[24:15], instr_d[11:7]};

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        if (instr_d[1:0] == 2'b11) begin
            case (instr_d[6:0])
                7'b0110111: begin legal = 1'b1; dec.regwrite = 1'b1; dec.resultsrc = 2'b11;
                                  dec.alusrc = 1'b1; dec.immsrc = IMM_U; end
                7'b0010111: begin legal = 1'b1; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
                                  dec.alu_a_pc = 1'b1; dec.immsrc = IMM_U; end
                7'b1101111: begin legal = 1'b1; dec.regwrite = 1'b1; dec.resultsrc = 2'b10;
                                  dec.immsrc = IMM_J; dec.jump = 1'b1; end
                7'b1100111: begin legal = (f3 == 3'b000); dec.regwrite = 1'b1; dec.resultsrc = 2'b10;
                                  dec.alusrc = 1'b1; dec.jump = 1'b1; dec.is_jalr = 1'b1; end
                7'b1100011: begin
                    legal = (f3[2:1] != 2'b01);
                    dec.branch = 1'b1;
                    dec.immsrc = IMM_B;
                    dec.aluctrl = !f3[2] ? A_SUB : (f3[1] ? A_SLTU : A_SLT);
                end
                7'b0000011: begin legal = (f3 != 3'b111); dec.regwrite = 1'b1;
                                  dec.resultsrc = 2'b01; dec.alusrc = 1'b1; end
                7'b0100011: begin legal = !f3[2]; dec.memwrite = 1'b1; dec.alusrc = 1'b1;
                                  dec.immsrc = IMM_S; end
                7'b0010011: begin
                    dec.regwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    legal        = 1'b1;
                    case (f3)
                        3'b000: dec.aluctrl = A_ADD;
                        3'b010: dec.aluctrl = A_SLT;
                        3'b011: dec.aluctrl = A_SLTU;
                        3'b100: dec.aluctrl = A_XOR;
                        3'b110: dec.aluctrl = A_OR;
                        3'b111: dec.aluctrl = A_AND;
                        3'b001: begin legal = (instr_d[31:26] == 6'b000000); dec.aluctrl = A_SLL; end
                        default: begin
                            legal = (instr_d[31:26] == 6'b000000) || (instr_d[31:26] == 6'b010000);
                            dec.aluctrl = instr_d[30] ? A_SRA : A_SRL;
                        end
                    endcase
                end
                7'b0011011: if (RV64) begin
                    dec.regwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    case (f3)
                        3'b000: begin legal = 1'b1; dec.aluctrl = A_ADDW; end
                        3'b001: begin legal = (f7 == 7'b0000000); dec.aluctrl = A_SLLW; end
                        3'b101: begin legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                                      dec.aluctrl = f7[5] ? A_SRAW : A_SRLW; end
                        default: ;
                    endcase
                end
                7'b0110011: begin
                    dec.regwrite = 1'b1;
                    case (f7)
                        7'b0000000: begin
                            legal = 1'b1;
                            case (f3)
                                3'b000: dec.aluctrl = A_ADD;
                                3'b001: dec.aluctrl = A_SLL;
                                3'b010: dec.aluctrl = A_SLT;
                                3'b011: dec.aluctrl = A_SLTU;
                                3'b100: dec.aluctrl = A_XOR;
                                3'b101: dec.aluctrl = A_SRL;
                                3'b110: dec.aluctrl = A_OR;
                                default: dec.aluctrl = A_AND;
                            endcase
                        end
                        7'b0100000: case (f3)
                            3'b000: begin legal = 1'b1; dec.aluctrl = A_SUB; end
                            3'b101: begin legal = 1'b1; dec.aluctrl = A_SRA; end
                            default: ;
                        endcase
                        7'b0010000: if (EN_ZBA) case (f3)
                            3'b010: begin legal = 1'b1; dec.aluctrl = A_SH1; end
                            3'b100: begin legal = 1'b1; dec.aluctrl = A_SH2; end
                            3'b110: begin legal = 1'b1; dec.aluctrl = A_SH3; end
                            default: ;
                        endcase
                        7'b0000001: if (EN_M) begin
                            legal = 1'b1; dec.md_en = 1'b1; dec.md_op = {1'b0, f3};
                        end
                        default: ;
                    endcase
                end
                7'b0111011: if (RV64) begin
                    dec.regwrite = 1'b1;
                    case (f7)
                        7'b0000000: case (f3)
                            3'b000: begin legal = 1'b1; dec.aluctrl = A_ADDW; end
                            3'b001: begin legal = 1'b1; dec.aluctrl = A_SLLW; end
                            3'b101: begin legal = 1'b1; dec.aluctrl = A_SRLW; end
                            default: ;
                        endcase
                        7'b0100000: case (f3)
                            3'b000: begin legal = 1'b1; dec.aluctrl = A_SUBW; end
                            3'b101: begin legal = 1'b1; dec.aluctrl = A_SRAW; end
                            default: ;
                        endcase
                        7'b0000100: if (EN_ZBA && f3 == 3'b000) begin legal = 1'b1; dec.aluctrl = A_ADDUW; end
                        7'b0010000: if (EN_ZBA) case (f3)
                            3'b010: begin legal = 1'b1; dec.aluctrl = A_SH1UW; end
                            3'b100: begin legal = 1'b1; dec.aluctrl = A_SH2UW; end
                            3'b110: begin legal = 1'b1; dec.aluctrl = A_SH3UW; end
                            default: ;
                        endcase
                        // Only MULW and the word divide/remainder forms exist in OP-32.
                        7'b0000001: if (EN_M && (f3 == 3'b000 || f3[2])) begin
                            legal = 1'b1; dec.md_en = 1'b1; dec.md_op = {1'b1, f3};
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign stall_o = (state_q == S_BUSY);
    assign md_done = stall_o && (cnt_q == '0) && !flush_e;

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_e) begin
            ctrl_d  = '0;
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_BUSY) begin
            // The front end is held during the last busy cycle, so E drains to a bubble.
            if (cnt_q == '0) begin
                ctrl_d  = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (!stall_e) begin
            ctrl_d = valid_d ? dec : '0;
            if (valid_d && dec.md_en) begin
                state_d = S_BUSY;
                cnt_d   = dec.md_op[2] ? DIV_CNT : MUL_CNT;
            end
        end
    end

    // ID/EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign regwrite_e  = ctrl_q.regwrite;
    assign memwrite_e  = ctrl_q.memwrite;
    assign resultsrc_e = ctrl_q.resultsrc;
    assign alusrc_e    = ctrl_q.alusrc;
    assign alu_a_pc_e  = ctrl_q.alu_a_pc;
    assign immsrc_e    = ctrl_q.immsrc;
    assign aluctrl_e   = ctrl_q.aluctrl;
    assign branch_e    = ctrl_q.branch;
    assign jump_e      = ctrl_q.jump;
    assign is_jalr_e   = ctrl_q.is_jalr;
    assign md_op_e     = ctrl_q.md_op;
    assign md_en_e     = ctrl_q.md_en;
    assign illegal_e   = ctrl_q.illegal;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Randomized bench for ctrl_decode_pipe: two configurations share stimulus and are
// compared every cycle against a pattern-table reference decoder and a busy-cycle model.
module tb_ctrl_decode_pipe;
    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic       alusrc;
        logic       alu_a_pc;
        logic [2:0] immsrc;
        logic [4:0] aluctrl;
        logic       branch;
        logic       jump;
        logic       is_jalr;
        logic [3:0] md_op;
        logic       md_en;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          kind;
        logic [4:0]  alu;
        bit          n64;
        bit          nzba;
        bit          nm;
    } ent_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6;
    localparam int K_LUI = 7, K_AUI = 8, K_M = 9;
    localparam logic [31:0] M_R = 32'hFE00707F, M_I = 32'h0000707F, M_SH6 = 32'hFC00707F, M_U = 32'h7F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        valid_d, stall_e, flush_e;
    ctrl_t       o1, o2;
    logic        so1, md1, so2, md2;

    ent_t  tab[$];
    ctrl_t exp_e[2];
    int    busy_left[2];
    bit    is64[2] = '{1'b1, 1'b0};
    bit    zba[2]  = '{1'b1, 1'b0};
    int    mlat[2] = '{3, 1};
    int    dlat[2] = '{34, 2};
    int    n_total = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    ctrl_decode_pipe #(.XLEN(64), .EN_ZBA(1'b1), .EN_M(1'b1), .MUL_LAT(3), .DIV_LAT(34)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
        .flush_e(flush_e), .regwrite_e(o1.regwrite), .memwrite_e(o1.memwrite),
        .resultsrc_e(o1.resultsrc), .alusrc_e(o1.alusrc), .alu_a_pc_e(o1.alu_a_pc),
        .immsrc_e(o1.immsrc), .aluctrl_e(o1.aluctrl), .branch_e(o1.branch), .jump_e(o1.jump),
        .is_jalr_e(o1.is_jalr), .md_op_e(o1.md_op), .md_en_e(o1.md_en), .illegal_e(o1.illegal),
        .stall_o(so1), .md_done(md1));

    ctrl_decode_pipe #(.XLEN(32), .EN_ZBA(1'b0), .EN_M(1'b1), .MUL_LAT(1), .DIV_LAT(2)) dut_rv32 (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e),
        .flush_e(flush_e), .regwrite_e(o2.regwrite), .memwrite_e(o2.memwrite),
        .resultsrc_e(o2.resultsrc), .alusrc_e(o2.alusrc), .alu_a_pc_e(o2.alu_a_pc),
        .immsrc_e(o2.immsrc), .aluctrl_e(o2.aluctrl), .branch_e(o2.branch), .jump_e(o2.jump),
        .is_jalr_e(o2.is_jalr), .md_op_e(o2.md_op), .md_en_e(o2.md_en), .illegal_e(o2.illegal),
        .stall_o(so2), .md_done(md2));

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t instr=%h)", tag, act, exp, $time, instr_d);
        end
    endtask

    function automatic logic [31:0] rop(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 10'b0, f3, 5'b0, opc};
    endfunction

    function automatic void add(input logic [31:0] mask, input logic [31:0] match, input int kind,
                                input logic [4:0] alu, input bit n64, input bit nzba, input bit nm);
        ent_t e;
        e.mask = mask; e.match = match; e.kind = kind; e.alu = alu;
        e.n64 = n64; e.nzba = nzba; e.nm = nm;
        tab.push_back(e);
    endfunction

    // Instruction patterns in the usual match/mask form, with the ALU op each one selects.
    task automatic build_table();
        logic [4:0] op_alu[8];
        op_alu = '{5'b00000, 5'b00101, 5'b01010, 5'b01011, 5'b00100, 5'b00110, 5'b00011, 5'b00010};
        add(M_U, 32'h37, K_LUI, 5'd0, 0, 0, 0);
        add(M_U, 32'h17, K_AUI, 5'd0, 0, 0, 0);
        add(M_U, 32'h6F, K_JAL, 5'd0, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd0, 7'h67), K_JALR, 5'd0, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd0, 7'h63), K_BR, 5'b00001, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd1, 7'h63), K_BR, 5'b00001, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd4, 7'h63), K_BR, 5'b01010, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd5, 7'h63), K_BR, 5'b01010, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd6, 7'h63), K_BR, 5'b01011, 0, 0, 0);
        add(M_I, rop(7'h0, 3'd7, 7'h63), K_BR, 5'b01011, 0, 0, 0);
        for (int f = 0; f < 7; f++) add(M_I, rop(7'h0, 3'(f), 7'h03), K_LD, 5'd0, 0, 0, 0);
        for (int f = 0; f < 4; f++) add(M_I, rop(7'h0, 3'(f), 7'h23), K_ST, 5'd0, 0, 0, 0);
        for (int f = 0; f < 8; f++)
            if (f != 1 && f != 5) add(M_I, rop(7'h0, 3'(f), 7'h13), K_I, op_alu[f], 0, 0, 0);
        add(M_SH6, rop(7'h00, 3'd1, 7'h13), K_I, 5'b00101, 0, 0, 0);
        add(M_SH6, rop(7'h00, 3'd5, 7'h13), K_I, 5'b00110, 0, 0, 0);
        add(M_SH6, rop(7'h20, 3'd5, 7'h13), K_I, 5'b00111, 0, 0, 0);
        add(M_I, rop(7'h00, 3'd0, 7'h1B), K_I, 5'b01000, 1, 0, 0);
        add(M_R, rop(7'h00, 3'd1, 7'h1B), K_I, 5'b01100, 1, 0, 0);
        add(M_R, rop(7'h00, 3'd5, 7'h1B), K_I, 5'b01101, 1, 0, 0);
        add(M_R, rop(7'h20, 3'd5, 7'h1B), K_I, 5'b01110, 1, 0, 0);
        for (int f = 0; f < 8; f++) add(M_R, rop(7'h00, 3'(f), 7'h33), K_R, op_alu[f], 0, 0, 0);
        add(M_R, rop(7'h20, 3'd0, 7'h33), K_R, 5'b00001, 0, 0, 0);
        add(M_R, rop(7'h20, 3'd5, 7'h33), K_R, 5'b00111, 0, 0, 0);
        add(M_R, rop(7'h10, 3'd2, 7'h33), K_R, 5'b10000, 0, 1, 0);
        add(M_R, rop(7'h10, 3'd4, 7'h33), K_R, 5'b10001, 0, 1, 0);
        add(M_R, rop(7'h10, 3'd6, 7'h33), K_R, 5'b10010, 0, 1, 0);
        for (int f = 0; f < 8; f++) add(M_R, rop(7'h01, 3'(f), 7'h33), K_M, 5'd0, 0, 0, 1);
        add(M_R, rop(7'h00, 3'd0, 7'h3B), K_R, 5'b01000, 1, 0, 0);
        add(M_R, rop(7'h00, 3'd1, 7'h3B), K_R, 5'b01100, 1, 0, 0);
        add(M_R, rop(7'h00, 3'd5, 7'h3B), K_R, 5'b01101, 1, 0, 0);
        add(M_R, rop(7'h20, 3'd0, 7'h3B), K_R, 5'b01001, 1, 0, 0);
        add(M_R, rop(7'h20, 3'd5, 7'h3B), K_R, 5'b01110, 1, 0, 0);
        add(M_R, rop(7'h04, 3'd0, 7'h3B), K_R, 5'b10011, 1, 1, 0);
        add(M_R, rop(7'h10, 3'd2, 7'h3B), K_R, 5'b10100, 1, 1, 0);
        add(M_R, rop(7'h10, 3'd4, 7'h3B), K_R, 5'b10101, 1, 1, 0);
        add(M_R, rop(7'h10, 3'd6, 7'h3B), K_R, 5'b10110, 1, 1, 0);
        for (int f = 0; f < 8; f++)
            if (f == 0 || f >= 4) add(M_R, rop(7'h01, 3'(f), 7'h3B), K_M, 5'd0, 1, 0, 1);
    endtask

    function automatic ctrl_t ref_decode(input logic [31:0] ins, input bit rv64, input bit hz);
        ctrl_t c;
        int hit;
        c = '0;
        hit = -1;
        foreach (tab[i]) if ((ins & tab[i].mask) == tab[i].match) hit = i;
        if (hit < 0 || (tab[hit].n64 && !rv64) || (tab[hit].nzba && !hz)) begin
            c.illegal = 1'b1;
            return c;
        end
        c.aluctrl = tab[hit].alu;
        case (tab[hit].kind)
            K_R:    c.regwrite = 1'b1;
            K_I:    begin c.regwrite = 1'b1; c.alusrc = 1'b1; end
            K_LD:   begin c.regwrite = 1'b1; c.resultsrc = 2'd1; c.alusrc = 1'b1; end
            K_ST:   begin c.memwrite = 1'b1; c.alusrc = 1'b1; c.immsrc = 3'd1; end
            K_BR:   begin c.branch = 1'b1; c.immsrc = 3'd2; end
            K_JAL:  begin c.regwrite = 1'b1; c.resultsrc = 2'd2; c.immsrc = 3'd3; c.jump = 1'b1; end
            K_JALR: begin c.regwrite = 1'b1; c.resultsrc = 2'd2; c.alusrc = 1'b1; c.jump = 1'b1;
                          c.is_jalr = 1'b1; end
            K_LUI:  begin c.regwrite = 1'b1; c.resultsrc = 2'd3; c.alusrc = 1'b1; c.immsrc = 3'd4; end
            K_AUI:  begin c.regwrite = 1'b1; c.alusrc = 1'b1; c.alu_a_pc = 1'b1; c.immsrc = 3'd4; end
            default: begin c.regwrite = 1'b1; c.md_en = 1'b1;
                           c.md_op = {ins[6:0] == 7'h3B, ins[14:12]}; end
        endcase
        return c;
    endfunction

    // busy_left counts the remaining cycles the M unit keeps the front end stalled.
    function automatic void mdl_step(input int d);
        if (flush_e) begin
            exp_e[d] = '0; busy_left[d] = 0;
        end else if (busy_left[d] == 1) begin
            exp_e[d] = '0; busy_left[d] = 0;
        end else if (busy_left[d] > 1) begin
            busy_left[d]--;
        end else if (!stall_e) begin
            exp_e[d] = valid_d ? ref_decode(instr_d, is64[d], zba[d]) : '0;
            if (exp_e[d].md_en) busy_left[d] = exp_e[d].md_op[2] ? dlat[d] : mlat[d];
        end
    endfunction

    task automatic cmp_all();
        chk_eq("rv64.ctrl", 32'(o1), 32'(exp_e[0]));
        chk_eq("rv64.stall_o", 32'(so1), 32'(busy_left[0] > 0));
        chk_eq("rv64.md_done", 32'(md1), 32'(busy_left[0] == 1 && !flush_e));
        chk_eq("rv32.ctrl", 32'(o2), 32'(exp_e[1]));
        chk_eq("rv32.stall_o", 32'(so2), 32'(busy_left[1] > 0));
        chk_eq("rv32.md_done", 32'(md2), 32'(busy_left[1] == 1 && !flush_e));
    endtask

    task automatic tick();
        #1 cmp_all();
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        #1;
    endtask

    task automatic drv(input logic [31:0] i, input logic v, input logic s, input logic f);
        instr_d = i; valid_d = v; stall_e = s; flush_e = f;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
        $fatal(1, "timeout");
    end

    initial begin
        int          n_st, n_done, r, k;
        logic [31:0] ins;
        ctrl_t       held;
        build_table();
        rst_n = 1'b0;
        drv(32'h0, 1'b0, 1'b0, 1'b0);
        exp_e = '{default: '0};
        busy_left = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset.ctrl", 32'(o1), 32'h0);
        chk_eq("reset.stall_o", 32'(so1), 32'h0);
        chk_eq("reset.md_done", 32'(md1), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        drv(32'h002081B3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_eq("add.regwrite", 32'(o1.regwrite), 32'h1);
        chk_eq("add.aluctrl", 32'(o1.aluctrl), 32'h0);
        chk_eq("add.alusrc", 32'(o1.alusrc), 32'h0);
        chk_eq("add.illegal", 32'(o1.illegal), 32'h0);

        drv(32'h2020A1B3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_eq("sh1add.aluctrl", 32'(o1.aluctrl), 32'h10);
        chk_eq("sh1add_nozba.illegal", 32'(o2.illegal), 32'h1);
        chk_eq("sh1add_nozba.regwrite", 32'(o2.regwrite), 32'h0);

        drv(32'h0220C1B3, 1'b1, 1'b0, 1'b0);
        tick();
        chk_eq("div.md_op", 32'(o1.md_op), 32'h4);
        chk_eq("div.md_en", 32'(o1.md_en), 32'h1);
        drv(32'h0, 1'b0, 1'b0, 1'b0);
        n_st = 0; n_done = 0;
        for (int c = 0; c < 40; c++) begin
            n_st += int'(so1); n_done += int'(md1);
            tick();
        end
        chk_eq("div.stall_cycles", 32'(n_st), 32'd34);
        chk_eq("div.done_pulses", 32'(n_done), 32'd1);

        drv(32'h0220C1B3, 1'b1, 1'b0, 1'b0);
        tick();
        drv(32'h0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        drv(32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drv(32'h0, 1'b0, 1'b0, 1'b0);
        chk_eq("div_flush.stall_o", 32'(so1), 32'h0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            n_done += int'(md1);
            tick();
        end
        chk_eq("div_flush.no_done", 32'(n_done), 32'd0);

        drv(32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_eq("zero.illegal", 32'(o1.illegal), 32'h1);
        chk_eq("zero.regwrite", 32'(o1.regwrite), 32'h0);
        held = o1;
        for (int c = 0; c < 3; c++) begin
            drv(32'h002081B3 ^ (32'(c) << 12), 1'b1, 1'b1, 1'b0);
            tick();
            chk_eq("stall_e.hold", 32'(o1), 32'(held));
        end

        drv(32'h022081B3, 1'b1, 1'b0, 1'b0);
        tick();
        drv(32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk_eq("mulrst.ctrl", 32'(o1), 32'h0);
        chk_eq("mulrst.stall_o", 32'(so1), 32'h0);
        chk_eq("mulrst.md_done", 32'(md1), 32'h0);
        exp_e = '{default: '0};
        busy_left = '{0, 0};
        #2 rst_n = 1'b1;
        tick();
        chk_eq("mulrst.idle_after", 32'(so1), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(99);
            k = $urandom_range(tab.size() - 1);
            if (tab[k].kind == K_M && $urandom_range(3) != 0) k = $urandom_range(tab.size() - 1);
            ins = tab[k].match | ($urandom & ~tab[k].mask);
            if (r >= 90) ins = $urandom;
            else if (r >= 75) ins[31:25] = 7'($urandom);
            drv(ins, $urandom_range(99) < 85, $urandom_range(99) < 15, $urandom_range(99) < 4);
            tick();
        end
        drv(32'h0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
